// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the write-back stage.
package wb_pkg;
   typedef enum logic {IDLE, LOAD_WAIT} state_t;
   localparam int DATA_W = 32;
   localparam int IDX_W = 4;
   localparam int NUM_REGS = 15;
   localparam logic [IDX_W-1:0] REG_PC = 4'd15;
endpackage

// File: rtl/wb_if.sv
// wb_if: MEM-stage inputs, memory read return and register-file write port.
// load_err exists only when WB_TIMEOUT_EN is defined.
interface wb_if;
   import wb_pkg::*;
   logic              in_valid;
   logic              in_wb_en;
   logic              in_mem_r_en;
   logic [IDX_W-1:0]  in_dest;
   logic [DATA_W-1:0] in_alu_result;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall;
   logic              wb_en;
   logic [IDX_W-1:0]  wb_dest;
   logic [DATA_W-1:0] wb_value;
`ifdef WB_TIMEOUT_EN
   logic              load_err;
`endif
   modport master (
      output in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result, mem_rvalid, mem_rdata,
      input stall, wb_en, wb_dest, wb_value
`ifdef WB_TIMEOUT_EN
      , load_err
`endif
   );
   modport slave (
      input in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result, mem_rvalid, mem_rdata,
      output stall, wb_en, wb_dest, wb_value
`ifdef WB_TIMEOUT_EN
      , load_err
`endif
   );
endinterface

// File: rtl/wb_load_timer.sv
// wb_load_timer: counts load-wait cycles and flags expiry on the last one.
module wb_load_timer #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_expire
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   assign o_expire = i_inc && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else     r_cnt <= (i_clr || o_expire) ? '0 : i_inc ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage retiring ALU results and loads, stalling upstream on slow loads.
// Optional load timeout with load_err pulse when WB_TIMEOUT_EN is defined.
module wb_stage
   import wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
) (
   input logic   clk,
   input logic   rst,
   wb_if.slave   i_bus
);
   state_t            r_state, w_state_nx;
   logic              r_ld_wb_en;
   logic [IDX_W-1:0]  r_ld_dest;
   logic              r_wb_en;
   logic [IDX_W-1:0]  r_wb_dest;
   logic [DATA_W-1:0] r_wb_value;
   logic              w_ret_idle, w_ret_wait, w_go_wait, w_wr, w_expire;
   logic [IDX_W-1:0]  w_dest_nx;
   logic [DATA_W-1:0] w_value_nx;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   always_comb begin
      w_ret_idle = r_state == IDLE && i_bus.in_valid && (!i_bus.in_mem_r_en || i_bus.mem_rvalid);
      w_ret_wait = r_state == LOAD_WAIT && i_bus.mem_rvalid;
      w_go_wait  = r_state == IDLE && i_bus.in_valid && i_bus.in_mem_r_en && !i_bus.mem_rvalid;
      w_dest_nx  = w_ret_wait ? r_ld_dest : i_bus.in_dest;
      w_wr       = (w_ret_idle ? i_bus.in_wb_en : w_ret_wait ? r_ld_wb_en : 1'b0) && (w_dest_nx != REG_PC);
      w_value_nx = (w_ret_wait || i_bus.in_mem_r_en) ? i_bus.mem_rdata : i_bus.in_alu_result;
      w_state_nx = w_go_wait ? LOAD_WAIT : (w_ret_wait || w_expire) ? IDLE : r_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ld_wb_en <= 1'b0;
         r_ld_dest  <= '0;
         r_wb_en    <= 1'b0;
         r_wb_dest  <= '0;
         r_wb_value <= '0;
      end else begin
         r_state <= w_state_nx;
         r_wb_en <= w_wr;
         if (w_wr) begin
            r_wb_dest  <= w_dest_nx;
            r_wb_value <= w_value_nx;
         end
         if (w_go_wait) begin
            r_ld_wb_en <= i_bus.in_wb_en;
            r_ld_dest  <= i_bus.in_dest;
         end
      end
   end

   // stall must drop during reset even though the input decode would still see a load
   assign i_bus.stall    = !rst && (r_state == LOAD_WAIT || w_go_wait);
   assign i_bus.wb_en    = r_wb_en;
   assign i_bus.wb_dest  = r_wb_dest;
   assign i_bus.wb_value = r_wb_value;

`ifdef WB_TIMEOUT_EN
   logic r_load_err;
   wb_load_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (r_state == LOAD_WAIT && !i_bus.mem_rvalid),
      .i_clr    (r_state != LOAD_WAIT),
      .o_expire (w_expire)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) r_load_err <= 1'b0;
      else     r_load_err <= w_expire;
   assign i_bus.load_err = r_load_err;
`else
   assign w_expire = 1'b0;
`endif
endmodule
